// File: rtl/emu_wb_host.sv
// Byte-stream to Wishbone bridge. Each command frame from the byte source becomes one
// Wishbone master cycle, and the result is returned as response bytes.
module emu_wb_host #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic        wbs_we_o,
    output logic [3:0]  wbs_sel_o,
    output logic [31:0] wbs_adr_o,
    output logic [31:0] wbs_dat_o,
    input  logic [31:0] wbs_dat_i,
    input  logic        wbs_ack_i,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        cyc_q, cyc_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rd_q, rd_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rx_fire;
    logic        resp_last;

    // Response byte idx of the current transaction: error marker, write ack, or read data MSB first.
    function automatic logic [7:0] resp_byte(input logic err, input logic we,
                                             input logic [31:0] rd, input logic [1:0] idx);
        logic [7:0] b;
        if (err) begin
            b = 8'h45;
        end else if (we) begin
            b = 8'h4B;
        end else begin
            case (idx)
                2'd0:    b = rd[31:24];
                2'd1:    b = rd[23:16];
                2'd2:    b = rd[15:8];
                default: b = rd[7:0];
            endcase
        end
        return b;
    endfunction

    assign rx_ready  = !wb_rst_i && (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA);
    assign rx_fire   = rx_valid && rx_ready;
    assign resp_last = err_q || we_q || (byte_cnt_q == 2'd3);

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign wbs_cyc_o = cyc_q;
    assign wbs_stb_o = cyc_q;
    assign wbs_we_o  = cyc_q && we_q;
    assign wbs_sel_o = {4{cyc_q}};
    assign wbs_adr_o = adr_q;
    assign wbs_dat_o = dat_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        we_d       = we_q;
        err_d      = err_q;
        cyc_d      = cyc_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rd_d       = rd_q;
        to_cnt_d   = to_cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            S_IDLE: begin
                byte_cnt_d = 2'd0;
                if (rx_fire && (rx_data == 8'h57 || rx_data == 8'h52)) begin
                    we_d    = (rx_data == 8'h57);
                    err_d   = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    adr_d      = {adr_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (we_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d  = S_BUS;
                            cyc_d    = 1'b1;
                            to_cnt_d = 16'd0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    dat_d      = {dat_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d  = S_BUS;
                        cyc_d    = 1'b1;
                        to_cnt_d = 16'd0;
                    end
                end
            end
            S_BUS: begin
                // Ack wins even on the cycle the timeout limit is reached.
                if (wbs_ack_i) begin
                    cyc_d      = 1'b0;
                    rd_d       = wbs_dat_i;
                    state_d    = S_RESP;
                    byte_cnt_d = 2'd0;
                end else if (to_cnt_q == TIMEOUT_LIMIT) begin
                    cyc_d      = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_RESP;
                    byte_cnt_d = 2'd0;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                // First RESP cycle loads the output register; later bytes load on each transfer.
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = resp_byte(err_q, we_q, rd_q, byte_cnt_q);
                end else if (tx_ready) begin
                    if (resp_last) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_data_d  = resp_byte(err_q, we_q, rd_q, byte_cnt_q + 2'd1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            cyc_q      <= 1'b0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            rd_q       <= 32'd0;
            to_cnt_q   <= 16'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            we_q       <= we_d;
            err_q      <= err_d;
            cyc_q      <= cyc_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rd_q       <= rd_d;
            to_cnt_q   <= to_cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end
endmodule

// File: tb/tb_emu_wb_host.sv
// Directed bench for emu_wb_host: frames in, Wishbone slave model, response bytes out.
module tb_emu_wb_host;
    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [3:0]  wbs_sel_o;
    logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
    logic        wbs_ack_i;
    logic        busy;

    emu_wb_host #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .wbs_cyc_o(wbs_cyc_o),
        .wbs_stb_o(wbs_stb_o),
        .wbs_we_o (wbs_we_o),
        .wbs_sel_o(wbs_sel_o),
        .wbs_adr_o(wbs_adr_o),
        .wbs_dat_o(wbs_dat_o),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_i(wbs_ack_i),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    // Wishbone slave: acks ack_delay cycles after cyc rises (negative = never).
    int          ack_delay = -1;
    int          slv_cnt   = 0;
    logic [31:0] slv_rdata = 32'd0;
    always @(posedge clk) slv_cnt <= wbs_cyc_o ? slv_cnt + 1 : 0;
    assign wbs_ack_i = wbs_cyc_o && wbs_stb_o && (ack_delay >= 0) && (slv_cnt == ack_delay);
    assign wbs_dat_i = slv_rdata;

    // Monitors, sampled on the falling edge.
    logic [7:0]  rxq[$];
    int          ack_count = 0, last_len = 0, cur_len = 0;
    int          tx_stab_err = 0, bus_stab_err = 0, ctl_err = 0;
    logic [31:0] log_adr, log_dat, adr0, dat0;
    logic [3:0]  log_sel;
    logic        log_we;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        first_seen = 1'b0;
    int          first_tx = 0, last_acc = 0;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) rxq.push_back(tx_data);
        if (prev_stall && tx_valid && tx_data != prev_data) tx_stab_err++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (tx_valid && !first_seen) begin
            first_seen = 1'b1;
            first_tx   = cyc_no;
        end
        if (wbs_cyc_o) begin
            if (cur_len == 0) begin
                adr0 = wbs_adr_o;
                dat0 = wbs_dat_o;
            end
            if (wbs_adr_o != adr0 || wbs_dat_o != dat0) bus_stab_err++;
            if (wbs_sel_o != 4'hF || !wbs_stb_o) ctl_err++;
            cur_len++;
        end else begin
            if (wbs_sel_o != 4'h0 || wbs_we_o || wbs_stb_o) ctl_err++;
            if (cur_len != 0) last_len = cur_len;
            cur_len = 0;
        end
        if (wbs_ack_i) begin
            log_adr = wbs_adr_o;
            log_dat = wbs_dat_o;
            log_sel = wbs_sel_o;
            log_we  = wbs_we_o;
            ack_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok       = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok       = 1'b1;
                last_acc = cyc_no;
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (!ok) check("rx_handshake", 32'(ok), 32'd1);
    endtask

    task automatic send_frame(input byte_q_t f);
        foreach (f[i]) send_byte(f[i]);
    endtask

    // Let the response drain until the block returns to IDLE; stall=1 gives ready 1 of 4 cycles.
    task automatic run_resp(input int stall);
        logic done;
        int   phase;
        done  = 1'b0;
        phase = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (stall != 0) tx_ready = ((phase % 4) == 3);
            phase++;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        tx_ready = 1'b1;
        check("resp_done", 32'(done), 32'd1);
    endtask

    task automatic check_resp(input string tag, input byte_q_t exp);
        check({tag, "_len"}, 32'(rxq.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < rxq.size()) check({tag, "_byte"}, 32'(rxq[i]), 32'(exp[i]));
        end
        $display("[TB] %s: %0d response bytes received", tag, rxq.size());
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int a0, s0;

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        idle(2);
        @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cyc", 32'(wbs_cyc_o), 32'd0);
        check("rst_adr", wbs_adr_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rx_ready", 32'(rx_ready), 32'd1);
        idle(1);

        // Write frame, slave acks after 2 cycles.
        rxq.delete();
        ack_delay = 2;
        a0 = ack_count;
        send_frame('{8'h57, 8'h30, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
        run_resp(0);
        check("wr_acks", 32'(ack_count - a0), 32'd1);
        check("wr_adr", log_adr, 32'h3000_0004);
        check("wr_dat", log_dat, 32'hDEAD_BEEF);
        check("wr_sel", 32'(log_sel), 32'hF);
        check("wr_we", 32'(log_we), 32'd1);
        check("wr_cyc_len", 32'(last_len), 32'd3);
        check_resp("write", '{8'h4B});

        // Read with back-pressure between response bytes.
        rxq.delete();
        ack_delay = 0;
        slv_rdata = 32'h1234_5678;
        s0 = tx_stab_err;
        send_frame('{8'h52, 8'h30, 8'h00, 8'h00, 8'h08});
        run_resp(1);
        check("rd_we", 32'(log_we), 32'd0);
        check("rd_adr", log_adr, 32'h3000_0008);
        check("rd_tx_stable", 32'(tx_stab_err - s0), 32'd0);
        check_resp("read_stall", '{8'h12, 8'h34, 8'h56, 8'h78});

        // Timeout: no ack.
        rxq.delete();
        ack_delay = -1;
        a0 = ack_count;
        send_frame('{8'h52, 8'h30, 8'h00, 8'h00, 8'h0C});
        run_resp(0);
        check("to_cyc_len", 32'(last_len), 32'd5);
        check("to_no_ack", 32'(ack_count - a0), 32'd0);
        check_resp("timeout", '{8'h45});

        // Ack on the same cycle the timeout limit is reached.
        rxq.delete();
        ack_delay = 4;
        slv_rdata = 32'hA5A5_5A5A;
        send_frame('{8'h52, 8'h30, 8'h00, 8'h00, 8'h10});
        run_resp(0);
        check("prec_cyc_len", 32'(last_len), 32'd5);
        check_resp("ack_at_limit", '{8'hA5, 8'hA5, 8'h5A, 8'h5A});

        // Junk bytes, then a write; also best-case latency.
        rxq.delete();
        ack_delay = 0;
        send_byte(8'hFF);
        send_byte(8'h00);
        check("junk_idle", 32'(busy), 32'd0);
        first_seen = 1'b0;
        send_frame('{8'h57, 8'h30, 8'h00, 8'h00, 8'h14, 8'h01, 8'h02, 8'h03, 8'h04});
        run_resp(0);
        check("latency", 32'(first_tx - last_acc), 32'd3);
        check("junk_wr_adr", log_adr, 32'h3000_0014);
        check("junk_wr_dat", log_dat, 32'h0102_0304);
        check_resp("junk_write", '{8'h4B});

        // Reset after 3 address bytes, then a full read.
        rxq.delete();
        send_frame('{8'h52, 8'h30, 8'h00, 8'h00});
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
        idle(1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_adr", wbs_adr_o, 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        ack_delay = 1;
        slv_rdata = 32'hCAFE_F00D;
        send_frame('{8'h52, 8'h30, 8'h00, 8'h00, 8'h18});
        run_resp(0);
        check("after_rst_adr", log_adr, 32'h3000_0018);
        check_resp("read_after_rst", '{8'hCA, 8'hFE, 8'hF0, 8'h0D});

        // Reset while the Wishbone cycle is open.
        rxq.delete();
        ack_delay = -1;
        send_frame('{8'h52, 8'h30, 8'h00, 8'h00, 8'h1C});
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(10);
        check("bus_rst_cyc", 32'(wbs_cyc_o), 32'd0);
        check("bus_rst_busy", 32'(busy), 32'd0);
        check_resp("bus_rst", '{});

        check("bus_stable", 32'(bus_stab_err), 32'd0);
        check("bus_ctl", 32'(ctl_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/emu_wb_host.md
EMU_WB_HOST -- requirements
Module: emu_wb_host

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL be the number of bus cycles waited for wbs_ack_i before abort (legal range 1..65535).
REQ-002 wb_clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004 rx_valid  in  1  command byte available from upstream byte source.
REQ-005 rx_data  in  8  command byte.
REQ-006 rx_ready  out  1  block accepts rx_data; a byte transfers when rx_valid&rx_ready.
REQ-007 tx_valid  out  1  response byte available.
REQ-008 tx_data  out  8  response byte.
REQ-009 tx_ready  in  1  downstream accepts; a byte transfers when tx_valid&tx_ready.
REQ-010 wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1 each  Wishbone master controls, driving the user_project_wrapper wbs_cyc_i/stb_i/we_i.
REQ-011 wbs_sel_o  out  4; wbs_adr_o  out  32; wbs_dat_o  out  32  Wishbone master byte-select, address, write data.
REQ-012 wbs_dat_i  in  32; wbs_ack_i  in  1  Wishbone read data and acknowledge from the wrapper.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 Frame formats SHALL be: write = 0x57, ADDR[31:24], ADDR[23:16], ADDR[15:8], ADDR[7:0], DATA[31:24]..DATA[7:0] (9 bytes); read = 0x52 followed by the same 4 address bytes (5 bytes).
REQ-015 FSM states SHALL be IDLE, ADDR, DATA, BUS, RESP; a 2-bit byte counter SHALL index ADDR/DATA bytes.
REQ-016 rx_ready SHALL be 1 in IDLE, ADDR, DATA and 0 in BUS and RESP.
REQ-017 IDLE: accepted byte 0x57 -> ADDR with we latched 1; 0x52 -> ADDR with we latched 0; any other byte SHALL be consumed and discarded, remaining in IDLE.
REQ-018 ADDR: each accepted byte SHALL shift into wbs_adr_o MSB first; after the 4th byte -> DATA if write, else BUS.
REQ-019 DATA: each accepted byte SHALL shift into wbs_dat_o MSB first; after the 4th byte -> BUS.
REQ-020 wbs_cyc_o and wbs_stb_o SHALL be registered, asserting on the first cycle in BUS (one cycle after the last frame byte is accepted) and held until ack or timeout; wbs_sel_o SHALL be 4'hF and wbs_we_o the latched type while cyc is high, 0 otherwise.
REQ-021 wbs_adr_o and wbs_dat_o SHALL remain stable for the whole BUS state.
REQ-022 A cycle with wbs_ack_i=1 in BUS SHALL end the transaction: cyc/stb 0 the next cycle, wbs_dat_i captured into a 32-bit read register on that cycle, transition to RESP.
REQ-023 wbs_ack_i outside BUS SHALL be ignored.
REQ-024 A 16-bit timeout counter SHALL clear on entering BUS and increment each BUS cycle without ack; when it reaches TIMEOUT_CYCLES, cyc/stb SHALL drop the next cycle and RESP SHALL emit a single error byte 0x45.
REQ-025 Ack on the same cycle the counter reaches TIMEOUT_CYCLES: ack SHALL take precedence (normal response).
REQ-026 RESP success: write SHALL emit the single byte 0x4B; read SHALL emit 4 bytes, read data MSB first.
REQ-027 tx_valid SHALL be 1 only in RESP; tx_data SHALL stay stable while tx_valid&!tx_ready; after the last response byte transfers -> IDLE the next cycle.
REQ-028 Best-case latency, last frame byte accepted to first tx_valid with ack returned combinationally on the first stb cycle: 3 cycles.

Reset
REQ-029 While wb_rst_i=1 at a clock edge: state IDLE, counters 0, wbs_cyc_o=wbs_stb_o=wbs_we_o=0, wbs_sel_o=0, wbs_adr_o=wbs_dat_o=0, read register 0, tx_valid=0, tx_data=0, busy=0; rx_ready SHALL be 0 during reset and 1 the first cycle after.
REQ-030 Reset mid-frame or mid-bus-cycle SHALL abandon the partial frame and any open Wishbone cycle without emitting a response.

Verification
REQ-031 Write 57 30 00 00 04 DE AD BE EF, slave acks after 2 cycles -> one Wishbone write with adr 0x30000004, dat 0xDEADBEEF, sel F; response byte 0x4B.
REQ-032 Read 52 30 00 00 08, slave returns 0x12345678 with ack -> tx bytes 12 34 56 78; tx_ready held low 3 cycles between bytes -> tx_data stable, no byte lost or repeated.
REQ-033 Read with no ack, TIMEOUT_CYCLES=4 -> cyc/stb high exactly 5 cycles, response single byte 0x45, return to IDLE.
REQ-034 Bytes 0xFF 0x00 then a valid write frame -> junk bytes discarded, write executes normally with response 0x4B.
REQ-035 Reset asserted after 3 address bytes, then a full read frame -> no response for the aborted frame; read completes correctly.
